// File: rtl/sa3_pkg.sv
// Shared constants and state encoding for the 3x3 systolic-array tile sequencer.
package sa3_pkg;

  localparam int DW  = 8;
  localparam int N_B = 9;
  localparam int N_A = 16;
  localparam int N_C = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } sa3_state_e;

  // Bit offset of operand byte idx inside a flattened, byte-packed operand bus.
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/sa3_result_serializer.sv
// Holds the four 2x2 result bytes and drains them over a valid/ready byte port,
// flagging the final (c22) byte with out_last.
module sa3_result_serializer
  import sa3_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          last_xfer
);

  logic [DW-1:0] res_r [N_C];
  logic [1:0]    idx_r;
  logic          valid_r;
  logic          last_r;
  logic [DW-1:0] data_r;
  logic [1:0]    idx_nxt_s;

  // Index of the byte presented after the current one is accepted.
  always_comb begin
    idx_nxt_s = idx_r + 2'd1;
  end

  // Capture results on load, then step one byte per accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_C; i++) begin
        res_r[i] <= '0;
      end
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      res_r[0] <= c11;
      res_r[1] <= c12;
      res_r[2] <= c21;
      res_r[3] <= c22;
      idx_r    <= 2'd0;
      valid_r  <= 1'b1;
      last_r   <= 1'b0;
      data_r   <= c11;
    end else if (valid_r && out_ready) begin
      if (idx_r == 2'(N_C - 1)) begin
        idx_r   <= 2'd0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
        data_r  <= '0;
      end else begin
        idx_r  <= idx_nxt_s;
        data_r <= res_r[idx_nxt_s];
        last_r <= (idx_nxt_s == 2'(N_C - 1));
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_last  = last_r;
  assign last_xfer = valid_r & out_ready & last_r;

endmodule

// File: rtl/sa3_tile_sequencer.sv
// Host-side sequencer for the 3x3 systolic array: loads 9 filter + 16 tile bytes,
// runs the array until done_sa3, then drains the 2x2 result. Optional RUN watchdog: SA3_TIMEOUT_EN.
module sa3_tile_sequencer
  import sa3_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [N_A*DW-1:0] a_flat,
  output logic [N_B*DW-1:0] b_flat,
  output logic              active_sa3,
  input  logic              done_sa3,
  input  logic [DW-1:0]     c11,
  input  logic [DW-1:0]     c12,
  input  logic [DW-1:0]     c21,
  input  logic [DW-1:0]     c22,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);

  sa3_state_e        state_r;
  logic [3:0]        cnt_r;
  logic [N_A*DW-1:0] a_r;
  logic [N_B*DW-1:0] b_r;
  logic              in_ready_r;
  logic              active_r;
  logic              busy_r;
  logic              accept_s;
  logic              done_run_s;
  logic              last_xfer_s;

`ifdef SA3_TIMEOUT_EN
  localparam int RUN_CW = $clog2(TIMEOUT);
  logic [RUN_CW-1:0] run_cnt_r;
  logic              err_r;
`endif

  // Byte handshake and the only done_sa3 sample that matters (RUN state).
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    done_run_s = (state_r == ST_RUN) & done_sa3;
  end

  // Sequencer FSM: operand capture, array run request and drain hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      a_r        <= '0;
      b_r        <= '0;
      in_ready_r <= 1'b0;
      active_r   <= 1'b0;
      busy_r     <= 1'b0;
`ifdef SA3_TIMEOUT_EN
      run_cnt_r  <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_LOAD_B;
          cnt_r      <= 4'd0;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b1;
        end
        ST_LOAD_B: begin
          if (accept_s) begin
            b_r[byte_lsb(cnt_r) +: DW] <= in_data;
            if (cnt_r == 4'(N_B - 1)) begin
              state_r <= ST_LOAD_A;
              cnt_r   <= 4'd0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        ST_LOAD_A: begin
          if (accept_s) begin
            a_r[byte_lsb(cnt_r) +: DW] <= in_data;
            // Last tile byte: stop accepting and raise the run request together.
            if (cnt_r == 4'(N_A - 1)) begin
              state_r    <= ST_RUN;
              cnt_r      <= 4'd0;
              in_ready_r <= 1'b0;
              active_r   <= 1'b1;
`ifdef SA3_TIMEOUT_EN
              run_cnt_r  <= '0;
`endif
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (done_sa3) begin
            state_r  <= ST_DRAIN;
            cnt_r    <= 4'd0;
            active_r <= 1'b0;
          end
`ifdef SA3_TIMEOUT_EN
          else if (run_cnt_r == RUN_CW'(TIMEOUT - 1)) begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b1;
          end else begin
            run_cnt_r <= run_cnt_r + RUN_CW'(1);
          end
`endif
        end
        ST_DRAIN: begin
          if (last_xfer_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= 4'd0;
          in_ready_r <= 1'b0;
          active_r   <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  sa3_result_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (done_run_s),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .last_xfer (last_xfer_s)
  );

  assign in_ready   = in_ready_r;
  assign a_flat     = a_r;
  assign b_flat     = b_r;
  assign active_sa3 = active_r;
  assign busy       = busy_r;

`ifdef SA3_TIMEOUT_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
